// File: rtl/adder_pkg.sv
// Shared defaults, stage-register layout and overflow helper for pipe_adder.
// Saturation is selected at build time with PIPE_ADDER_SATURATE_EN.
package adder_pkg;

    localparam int ADDER_N_DEFAULT      = 8;
    localparam int ADDER_STAGES_DEFAULT = 2;

    // Reference layout of one pipeline stage register at the default width.
    // The top module declares the same layout sized by its own N parameter.
    typedef struct packed {
        logic                       valid;
        logic                       carry;
        logic [ADDER_N_DEFAULT-1:0] sum;
        logic [ADDER_N_DEFAULT-1:0] a;
        logic [ADDER_N_DEFAULT-1:0] b;
    } adder_stage_t;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic adder_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit slice of the pipelined adder: {cout, sum} = a + b + cin.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined N-bit signed adder with valid/ready handshake and whole-pipe stall.
// Define PIPE_ADDER_SATURATE_EN to clamp S on signed overflow.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int N      = ADDER_N_DEFAULT,
    parameter int STAGES = ADDER_STAGES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         co,
    output logic         ovf
);

    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;

`ifdef PIPE_ADDER_SATURATE_EN
    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};
`endif

    typedef struct packed {
        logic         valid;
        logic         carry;
        logic [N-1:0] sum;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } stage_t;

    stage_t       st_q [STAGES];
    stage_t       st_d [STAGES];
    logic         ovf_q;
    logic         ovf_d;
    logic         stall_s;

    logic [W-1:0] sl_a_s    [STAGES];
    logic [W-1:0] sl_b_s    [STAGES];
    logic [W-1:0] sl_sum_s  [STAGES];
    logic         sl_cin_s  [STAGES];
    logic         sl_cout_s [STAGES];

    // Stage k adds slice k; stage 0 takes the ports, later stages the previous register.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign sl_a_s[k]   = A[W-1:0];
            assign sl_b_s[k]   = B[W-1:0];
            assign sl_cin_s[k] = ci;
        end else begin : g_next
            assign sl_a_s[k]   = st_q[k-1].a[k*W +: W];
            assign sl_b_s[k]   = st_q[k-1].b[k*W +: W];
            assign sl_cin_s[k] = st_q[k-1].carry;
        end

        adder_slice #(
            .W (W)
        ) u_slice (
            .a    (sl_a_s[k]),
            .b    (sl_b_s[k]),
            .cin  (sl_cin_s[k]),
            .sum  (sl_sum_s[k]),
            .cout (sl_cout_s[k])
        );
    end

    // Next-state of every stage: forward the previous stage and merge in this slice's result.
    always_comb begin
        st_d[0] = '{valid: in_valid, carry: ci, sum: '0, a: A, b: B};
        for (int k = 1; k < STAGES; k++) begin
            st_d[k] = st_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            st_d[k].sum[k*W +: W] = sl_sum_s[k];
            st_d[k].carry         = sl_cout_s[k];
        end
        ovf_d = adder_ovf(st_d[L].a[N-1], st_d[L].b[N-1], st_d[L].sum[N-1]);
`ifdef PIPE_ADDER_SATURATE_EN
        st_d[L].sum = ovf_d ? (st_d[L].a[N-1] ? SAT_NEG : SAT_POS) : st_d[L].sum;
`endif
    end

    assign stall_s   = st_q[L].valid & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = st_q[L].valid;
    assign S         = st_q[L].sum;
    assign co        = st_q[L].carry;
    assign ovf       = ovf_q;

    // Stage registers: reset clears everything, a stall freezes the whole pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall_s) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder at N=8, STAGES=2.
module tb_pipe_adder;

    localparam int N      = 8;
    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] S;
    logic         co;
    logic         ovf;

    int           checks   = 0;
    int           failures = 0;
    logic [9:0]   exp_q [$];
    logic [9:0]   e;

    always #5 clk = ~clk;

    pipe_adder #(
        .N      (N),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .co        (co),
        .ovf       (ovf)
    );

    // Reference: {co, ovf, S} from a plain 9-bit addition.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] sum9;
        logic [7:0] s;
        logic       v;
        sum9 = {1'b0, a} + {1'b0, b} + {8'd0, c};
        s    = sum9[7:0];
        v    = (a[7] == b[7]) && (s[7] != a[7]);
`ifdef PIPE_ADDER_SATURATE_EN
        if (v) s = a[7] ? 8'h80 : 8'h7F;
`endif
        return {sum9[8], v, s};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; A = 8'd0; B = 8'd0; ci = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || S !== 8'd0 || co !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%0b S=%0h co=%0b ovf=%0b, want all 0", out_valid, S, co, ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got in_ready=%0b out_valid=%0b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [7:0] va [4] = '{8'd5, 8'd127, 8'h80, 8'hFF};
        logic [7:0] vb [4] = '{8'd10, 8'd1, 8'hFF, 8'h00};
        logic       vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; A = va[i]; B = vb[i]; ci = vc[i]; out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL directed_accept[%0d]: got in_ready=%0b, want 1", i, in_ready);
            end
            exp_q.push_back(model(A, B, ci));
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL directed_early[%0d]: got out_valid=%0b after 1 cycle, want 0", i, out_valid);
            end
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {co, ovf, S} !== e) begin
                failures++;
                $display("FAIL directed_result[%0d]: got v=%0b co=%0b ovf=%0b S=%0h, want v=1 co=%0b ovf=%0b S=%0h",
                         i, out_valid, co, ovf, S, e[9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int stall_left = 0;
        bit seen = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            if (out_valid && !seen) begin
                seen = 1'b1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            in_valid  = (sent < 3);
            A = 8'(sent + 1); B = 8'(sent + 1); ci = 1'b0;
            @(negedge clk);
            if (stall_left > 0) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || S !== 8'd2) begin
                    failures++;
                    $display("FAIL b2b_stall: got in_ready=%0b v=%0b S=%0h, want 0 1 02", in_ready, out_valid, S);
                end
                stall_left--;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(A, B, ci));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra: got unexpected S=%0h, want no output", S);
                end else begin
                    e = exp_q.pop_front();
                    if ({co, ovf, S} !== e) begin
                        failures++;
                        $display("FAIL b2b_result: got co=%0b ovf=%0b S=%0h, want co=%0b ovf=%0b S=%0h",
                                 co, ovf, S, e[9], e[8], e[7:0]);
                    end
                end
                got++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got != 3 || sent != 3 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count: got outputs=%0d sent=%0d left=%0d, want 3 3 0", got, sent, exp_q.size());
        end
    endtask

    task automatic test_reset_inflight();
        @(posedge clk); #1;
        in_valid = 1'b1; A = 8'd10; B = 8'd20; ci = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        A = 8'd30; B = 8'd40;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b1; A = 8'd7; B = 8'd8; ci = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_flush: got out_valid=%0b in_ready=%0b, want 0 1", out_valid, in_ready);
        end
        exp_q.delete();
        exp_q.push_back(model(A, B, ci));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_stale: got out_valid=%0b S=%0h, want 0", out_valid, S);
        end
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {co, ovf, S} !== e) begin
            failures++;
            $display("FAIL rst_next: got v=%0b S=%0h co=%0b, want v=1 S=%0h co=%0b", out_valid, S, co, e[7:0], e[9]);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_ghost: got out_valid=%0b S=%0h, want 0", out_valid, S);
            end
        end
    endtask

    task automatic test_random();
        int got = 0;
        int sent = 0;
        logic [7:0] prev_s = 8'd0;
        bit prev_stall = 1'b0;
        for (int cyc = 0; cyc < 340; cyc++) begin
            @(posedge clk); #1;
            checks++;
            if (prev_stall && (out_valid !== 1'b1 || S !== prev_s)) begin
                failures++;
                $display("FAIL rand_hold: got v=%0b S=%0h, want 1 %0h", out_valid, S, prev_s);
            end
            in_valid  = (cyc < 300) ? ($urandom_range(3) != 0) : 1'b0;
            out_ready = (cyc < 300) ? ($urandom_range(2) != 0) : 1'b1;
            A = 8'($urandom); B = 8'($urandom); ci = 1'($urandom);
            @(negedge clk);
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                failures++;
                $display("FAIL rand_ready: got in_ready=%0b, want %0b", in_ready, !(out_valid && !out_ready));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(A, B, ci));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra: got unexpected S=%0h, want no output", S);
                end else begin
                    e = exp_q.pop_front();
                    if ({co, ovf, S} !== e) begin
                        failures++;
                        $display("FAIL rand_result: got co=%0b ovf=%0b S=%0h, want co=%0b ovf=%0b S=%0h",
                                 co, ovf, S, e[9], e[8], e[7:0]);
                    end
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_s     = S;
        end
        checks++;
        if (exp_q.size() != 0 || got != sent || sent == 0) begin
            failures++;
            $display("FAIL rand_drain: got outputs=%0d sent=%0d left=%0d, want equal and empty", got, sent, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
